// File: rtl/axioma_tick_sch_pkg.sv
// Shared definitions for the tick scheduler: register addresses, CTRL/MODE bit
// positions, channel state encoding and the round-robin pointer helper.
package axioma_tick_sch_pkg;

    localparam logic [5:0] ADDR_CTRL  = 6'h39;
    localparam logic [5:0] ADDR_SEL   = 6'h3A;
    localparam logic [5:0] ADDR_CNT_L = 6'h3B;
    localparam logic [5:0] ADDR_CNT_H = 6'h3C;
    localparam logic [5:0] ADDR_MODE  = 6'h3D;
    localparam logic [5:0] ADDR_FLAGS = 6'h3E;
    localparam logic [5:0] ADDR_VEC   = 6'h3F;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam int MODE_PERIODIC = 0;
    localparam int MODE_IE       = 1;
    localparam int MODE_TB_US    = 2;
    localparam int MODE_OVR      = 7;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ARMED = 2'd1,
        CH_DONE  = 2'd2
    } ch_state_t;

    // Channel index after v, wrapping at n channels.
    function automatic logic [2:0] rr_next(input logic [2:0] v, input int n);
        if (int'(v) >= n - 1) return 3'd0;
        return v + 3'd1;
    endfunction

endpackage

// File: rtl/axioma_tick_sch_if.sv
// I/O bus and interrupt handshake of the tick scheduler.
// master = CPU side, slave = scheduler side.
interface axioma_tick_sch_if;
    logic [5:0] io_addr;
    logic [7:0] io_data_in;
    logic [7:0] io_data_out;
    logic       io_read;
    logic       io_write;
    logic       irq;
    logic [2:0] irq_vector;
    logic       irq_ack;

    modport master (
        output io_addr, io_data_in, io_read, io_write, irq_ack,
        input  io_data_out, irq, irq_vector
    );

    modport slave (
        input  io_addr, io_data_in, io_read, io_write, irq_ack,
        output io_data_out, irq, irq_vector
    );
endinterface

// File: rtl/axioma_tick_sch_channel.sv
// One countdown channel: period, count, IDLE/ARMED/DONE FSM, expired flag and
// (when AXIOMA_TICK_SCH_OVERRUN_EN is defined) the sticky overrun bit.
module axioma_tick_sch_channel
    import axioma_tick_sch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_commit,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_mode_we,
    input  logic [2:0]       i_mode_wdata,
    input  logic             i_tick_1ms,
    input  logic             i_tick_1us,
    input  logic             i_w1c,
    input  logic             i_ack,
    output logic [CNT_W-1:0] o_count,
    output logic [2:0]       o_mode,
    output logic             o_flag,
    output logic             o_ovr,
    output logic             o_active
);

    ch_state_t        r_state;
    ch_state_t        w_state_next;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_mode;
    logic             r_flag;
    logic             w_tick;
    logic             w_step;
    logic             w_expire;

    // A tick coinciding with a commit is dropped so the new period starts clean.
    assign w_tick   = r_mode[MODE_TB_US] ? i_tick_1us : i_tick_1ms;
    assign w_step   = (r_state == CH_ARMED) && i_en && w_tick && !i_commit;
    assign w_expire = w_step && (r_count == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= CH_IDLE;
        else          r_state <= w_state_next;
    end

    // Next state: CLR, then commit (period 0 disarms), then one-shot expiry.
    always_comb begin
        w_state_next = r_state;
        if (i_clr)
            w_state_next = CH_IDLE;
        else if (i_commit)
            w_state_next = (i_period == '0) ? CH_IDLE : CH_ARMED;
        else if (w_expire && !r_mode[MODE_PERIODIC])
            w_state_next = CH_DONE;
    end

    // Outputs decoded from state.
    always_comb begin
        o_active = (r_state == CH_ARMED);
    end

    // Period, count, mode and flag; an expiry set beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= '0;
            r_count  <= '0;
            r_mode   <= 3'd0;
            r_flag   <= 1'b0;
        end else begin
            if (i_mode_we) r_mode <= i_mode_wdata;
            if (i_commit)  r_period <= i_period;

            if (i_clr)
                r_count <= '0;
            else if (i_commit)
                r_count <= i_period;
            else if (w_expire)
                r_count <= r_mode[MODE_PERIODIC] ? r_period : '0;
            else if (w_step)
                r_count <= r_count - CNT_W'(1);

            if (i_clr)
                r_flag <= 1'b0;
            else if (w_expire)
                r_flag <= 1'b1;
            else if (i_w1c || i_ack)
                r_flag <= 1'b0;
        end
    end

`ifdef AXIOMA_TICK_SCH_OVERRUN_EN
    logic r_ovr;

    // Sticky overrun: expiry while the previous one is still unacknowledged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ovr <= 1'b0;
        else if (i_clr)
            r_ovr <= 1'b0;
        else if (w_expire && r_flag)
            r_ovr <= 1'b1;
        else if (i_w1c || i_commit)
            r_ovr <= 1'b0;
    end

    assign o_ovr = r_ovr;
`else
    assign o_ovr = 1'b0;
`endif

    assign o_count = r_count;
    assign o_mode  = r_mode;
    assign o_flag  = r_flag;

endmodule

// File: rtl/axioma_tick_scheduler.sv
// Multi-channel software-timer scheduler at I/O 0x39-0x3F: register decode,
// TEMP_W/TEMP_R byte staging, round-robin IRQ arbiter and read mux.
// Optional build macro: AXIOMA_TICK_SCH_OVERRUN_EN (per-channel overrun bit).
module axioma_tick_scheduler
    import axioma_tick_sch_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axioma_tick_sch_if.slave      bus,
    input  logic                  tick_1ms,
    input  logic                  tick_1us,
    output logic [NUM_CH-1:0]     ch_active
);

    logic             r_en;
    logic [2:0]       r_sel;
    logic [7:0]       r_temp_w;
    logic [7:0]       r_temp_r;
    logic             r_irq;
    logic [2:0]       r_vec;
    logic [2:0]       r_rr_ptr;

    logic             w_wr_ctrl, w_wr_sel, w_wr_cnt_l, w_wr_cnt_h, w_wr_mode, w_wr_flags;
    logic             w_rd_cnt_l, w_clr, w_ack_ok;
    logic [CNT_W-1:0] w_count [NUM_CH];
    logic [2:0]       w_mode  [NUM_CH];
    logic [NUM_CH-1:0] w_flag, w_ovr, w_ie, w_pending;
    logic [CNT_W-1:0] w_sel_count;
    logic [2:0]       w_sel_mode;
    logic             w_sel_ovr;
    logic             w_grant_found;
    logic [2:0]       w_grant;
    logic             w_vec_pending;
    logic [7:0]       w_rdata;

    assign w_wr_ctrl  = bus.io_write && (bus.io_addr == ADDR_CTRL);
    assign w_wr_sel   = bus.io_write && (bus.io_addr == ADDR_SEL);
    assign w_wr_cnt_l = bus.io_write && (bus.io_addr == ADDR_CNT_L);
    assign w_wr_cnt_h = bus.io_write && (bus.io_addr == ADDR_CNT_H);
    assign w_wr_mode  = bus.io_write && (bus.io_addr == ADDR_MODE);
    assign w_wr_flags = bus.io_write && (bus.io_addr == ADDR_FLAGS);
    assign w_rd_cnt_l = bus.io_read  && (bus.io_addr == ADDR_CNT_L);
    assign w_clr      = w_wr_ctrl && bus.io_data_in[CTRL_CLR];
    // An ack only means something while a grant is outstanding.
    assign w_ack_ok   = r_irq && bus.irq_ack;
    assign w_pending  = w_flag & w_ie;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            axioma_tick_sch_channel #(.CNT_W(CNT_W)) u_ch (
                .clk          (clk),
                .reset_n      (reset_n),
                .i_clr        (w_clr),
                .i_en         (r_en),
                .i_commit     (w_wr_cnt_h && (r_sel == 3'(gi))),
                .i_period     (CNT_W'({bus.io_data_in, r_temp_w})),
                .i_mode_we    (w_wr_mode && (r_sel == 3'(gi))),
                .i_mode_wdata (bus.io_data_in[2:0]),
                .i_tick_1ms   (tick_1ms),
                .i_tick_1us   (tick_1us),
                .i_w1c        (w_wr_flags && bus.io_data_in[gi]),
                .i_ack        (w_ack_ok && (r_vec == 3'(gi))),
                .o_count      (w_count[gi]),
                .o_mode       (w_mode[gi]),
                .o_flag       (w_flag[gi]),
                .o_ovr        (w_ovr[gi]),
                .o_active     (ch_active[gi])
            );
            assign w_ie[gi] = w_mode[gi][MODE_IE];
        end
    endgenerate

    // Control, select and byte staging registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en     <= 1'b1;
            r_sel    <= 3'd0;
            r_temp_w <= 8'd0;
            r_temp_r <= 8'd0;
        end else begin
            if (w_wr_ctrl) r_en <= bus.io_data_in[CTRL_EN];
            if (w_wr_sel && (int'(bus.io_data_in[2:0]) < NUM_CH))
                r_sel <= bus.io_data_in[2:0];
            if (w_wr_cnt_l) r_temp_w <= bus.io_data_in;
            // Snapshot the high byte so a CNT_L/CNT_H read pair is coherent.
            if (w_rd_cnt_l) r_temp_r <= w_sel_count[15:8];
        end
    end

    // Selected-channel view for the read mux.
    always_comb begin
        w_sel_count   = '0;
        w_sel_mode    = 3'd0;
        w_sel_ovr     = 1'b0;
        w_vec_pending = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_sel == 3'(k)) begin
                w_sel_count = w_count[k];
                w_sel_mode  = w_mode[k];
                w_sel_ovr   = w_ovr[k];
            end
            if (r_vec == 3'(k)) w_vec_pending = w_pending[k];
        end
    end

    // Round-robin pick: first pending at or above the pointer, else lowest pending.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant       = 3'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_grant_found && w_pending[k] && (3'(k) >= r_rr_ptr)) begin
                w_grant_found = 1'b1;
                w_grant       = 3'(k);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_grant_found && w_pending[k]) begin
                w_grant_found = 1'b1;
                w_grant       = 3'(k);
            end
        end
    end

    // Grant register: frozen while irq is high, released by ack or by the
    // granted request disappearing (W1C or IE cleared).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq    <= 1'b0;
            r_vec    <= 3'd0;
            r_rr_ptr <= 3'd0;
        end else if (w_clr) begin
            r_irq    <= 1'b0;
            r_vec    <= 3'd0;
            r_rr_ptr <= 3'd0;
        end else if (!r_irq) begin
            if (w_grant_found) begin
                r_irq <= 1'b1;
                r_vec <= w_grant;
            end
        end else if (w_ack_ok) begin
            r_irq    <= 1'b0;
            r_rr_ptr <= rr_next(r_vec, NUM_CH);
        end else if (!w_vec_pending) begin
            r_irq <= 1'b0;
        end
    end

    // Combinational read mux; zero when not reading or unmapped.
    always_comb begin
        w_rdata = 8'd0;
        if (bus.io_read) begin
            case (bus.io_addr)
                ADDR_CTRL:  w_rdata = {7'd0, r_en};
                ADDR_SEL:   w_rdata = {5'd0, r_sel};
                ADDR_CNT_L: w_rdata = w_sel_count[7:0];
                ADDR_CNT_H: w_rdata = r_temp_r;
                ADDR_MODE:  w_rdata = {w_sel_ovr, 4'd0, w_sel_mode};
                ADDR_FLAGS: w_rdata = 8'(w_flag);
                ADDR_VEC:   w_rdata = {r_irq, 4'd0, r_vec};
                default:    w_rdata = 8'd0;
            endcase
        end
    end

    assign bus.io_data_out = w_rdata;
    assign bus.irq         = r_irq;
    assign bus.irq_vector  = r_vec;

endmodule

// File: tb/tb_axioma_tick_scheduler.sv
// Directed bench for axioma_tick_scheduler: stimulus pushes expected read data
// and expected IRQ grants (vector + cycle) into queues; a negedge monitor pops
// and compares whenever a read strobe or a rising irq appears.
module tb_axioma_tick_scheduler;

    localparam logic [5:0] A_CTRL  = 6'h39;
    localparam logic [5:0] A_SEL   = 6'h3A;
    localparam logic [5:0] A_CNT_L = 6'h3B;
    localparam logic [5:0] A_CNT_H = 6'h3C;
    localparam logic [5:0] A_MODE  = 6'h3D;
    localparam logic [5:0] A_FLAGS = 6'h3E;
    localparam logic [5:0] A_VEC   = 6'h3F;
`ifdef AXIOMA_TICK_SCH_OVERRUN_EN
    localparam logic [7:0] MODE_AFTER_OVERRUN = 8'h87;
`else
    localparam logic [7:0] MODE_AFTER_OVERRUN = 8'h07;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1ms = 1'b0;
    logic       tick_1us = 1'b0;
    logic [3:0] ch_active;

    axioma_tick_sch_if bus();

    axioma_tick_scheduler #(.NUM_CH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .tick_1ms  (tick_1ms),
        .tick_1us  (tick_1us),
        .ch_active (ch_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { string name; logic [7:0] val; } rd_exp_t;
    typedef struct { logic [2:0] vec; int at; } irq_exp_t;
    rd_exp_t  rd_q[$];
    irq_exp_t irq_q[$];
    rd_exp_t  mon_rd;
    irq_exp_t mon_irq;
    logic     prev_irq = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: compare read data on every read strobe and each new irq grant.
    always @(negedge clk) begin
        if (bus.io_read === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL read_unexpected: got 0x%0h required no read", bus.io_data_out);
            end else begin
                mon_rd = rd_q.pop_front();
                check(mon_rd.name, 32'(bus.io_data_out), 32'(mon_rd.val));
            end
        end
        if (bus.irq === 1'b1 && prev_irq === 1'b0) begin
            if (irq_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL irq_unexpected: got vector %0d at cycle %0d required no irq", bus.irq_vector, cyc);
            end else begin
                mon_irq = irq_q.pop_front();
                check("irq_vector", 32'(bus.irq_vector), 32'(mon_irq.vec));
                check("irq_cycle", 32'(cyc), 32'(mon_irq.at));
            end
        end
        prev_irq <= bus.irq;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        bus.io_addr = a; bus.io_data_in = d; bus.io_write = 1'b1;
        step();
        bus.io_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] e, input string n);
        rd_q.push_back('{name: n, val: e});
        bus.io_addr = a; bus.io_read = 1'b1;
        step();
        bus.io_read = 1'b0;
    endtask

    // One-cycle pulse of tick/ack; an irq grant driven by it appears two cycles later.
    task automatic pulse(input bit ms, input bit us, input bit ack, input bit exp_irq, input logic [2:0] v);
        if (exp_irq) irq_q.push_back('{vec: v, at: cyc + 2});
        tick_1ms = ms; tick_1us = us; bus.irq_ack = ack;
        step();
        tick_1ms = 1'b0; tick_1us = 1'b0; bus.irq_ack = 1'b0;
    endtask

    task automatic program_ch(input logic [2:0] ch, input logic [7:0] mode, input logic [15:0] period);
        wr(A_SEL, {5'd0, ch});
        wr(A_MODE, mode);
        wr(A_CNT_L, period[7:0]);
        wr(A_CNT_H, period[15:8]);
    endtask

    initial begin
        bus.io_addr = 6'd0; bus.io_data_in = 8'd0;
        bus.io_read = 1'b0; bus.io_write = 1'b0; bus.irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // Reset values
        check("rst_irq", 32'(bus.irq), 32'd0);
        check("rst_vector", 32'(bus.irq_vector), 32'd0);
        check("rst_active", 32'(ch_active), 32'd0);
        rd(A_CTRL, 8'h01, "rst_ctrl");
        rd(A_SEL, 8'h00, "rst_sel");
        rd(A_CNT_L, 8'h00, "rst_cnt_l");
        rd(A_CNT_H, 8'h00, "rst_cnt_h");
        rd(A_MODE, 8'h00, "rst_mode");
        rd(A_FLAGS, 8'h00, "rst_flags");
        rd(A_VEC, 8'h00, "rst_vec");
        rd(6'h10, 8'h00, "unmapped");

        // One-shot ch0, period 3, 1ms base
        program_ch(3'd0, 8'h02, 16'd3);
        check("t2_active", 32'(ch_active), 32'h1);
        pulse(1, 0, 0, 0, 3'd0); step();
        pulse(1, 0, 0, 0, 3'd0); step();
        pulse(1, 0, 0, 1, 3'd0);
        check("t2_irq_not_yet", 32'(bus.irq), 32'd0);
        rd(A_FLAGS, 8'h01, "t2_flags");
        rd(A_VEC, 8'h80, "t2_vec");
        check("t2_done", 32'(ch_active), 32'h0);
        rd(A_CNT_L, 8'h00, "t2_count0");
        pulse(0, 0, 1, 0, 3'd0);
        rd(A_FLAGS, 8'h00, "t2_flags_acked");
        rd(A_VEC, 8'h00, "t2_vec_acked");

        // Periodic ch1, period 2, 1us base
        program_ch(3'd1, 8'h07, 16'd2);
        for (int i = 0; i < 3; i++) begin
            pulse(0, 1, 0, 0, 3'd0);
            pulse(0, 1, 0, 1, 3'd1);
            step();
            check("t3_active", 32'(ch_active), 32'h2);
            pulse(0, 0, 1, 0, 3'd0);
            rd(A_FLAGS, 8'h00, "t3_flags");
            rd(A_VEC, 8'h01, "t3_vec");
        end

        // CLR then round-robin with pointer 0
        wr(A_CTRL, 8'h03);
        check("t4_clr_active", 32'(ch_active), 32'h0);
        rd(A_CTRL, 8'h01, "t4_ctrl");
        rd(A_FLAGS, 8'h00, "t4_flags_clr");
        program_ch(3'd0, 8'h02, 16'd1);
        program_ch(3'd2, 8'h02, 16'd1);
        program_ch(3'd3, 8'h02, 16'd1);
        pulse(1, 0, 0, 1, 3'd0); step();
        pulse(0, 0, 1, 1, 3'd2); step();
        pulse(0, 0, 1, 1, 3'd3); step();
        pulse(0, 0, 1, 0, 3'd0);
        // Serve ch0 alone so the pointer moves to 1
        program_ch(3'd0, 8'h02, 16'd1);
        pulse(1, 0, 0, 1, 3'd0); step();
        pulse(0, 0, 1, 0, 3'd0);
        program_ch(3'd0, 8'h02, 16'd1);
        program_ch(3'd2, 8'h02, 16'd1);
        program_ch(3'd3, 8'h02, 16'd1);
        pulse(1, 0, 0, 1, 3'd2); step();
        pulse(0, 0, 1, 1, 3'd3); step();
        pulse(0, 0, 1, 1, 3'd0); step();
        pulse(0, 0, 1, 0, 3'd0);

        // Byte-latched count readback, SEL range, disarm
        program_ch(3'd2, 8'h02, 16'h1234);
        rd(A_CNT_L, 8'h34, "t5_cnt_l");
        pulse(1, 0, 0, 0, 3'd0);
        rd(A_CNT_H, 8'h12, "t5_cnt_h_latched");
        rd(A_CNT_L, 8'h33, "t5_cnt_l_dec");
        wr(A_SEL, 8'h05);
        rd(A_SEL, 8'h02, "t5_sel_ignored");
        wr(A_CNT_L, 8'h00);
        wr(A_CNT_H, 8'h00);
        check("t5_idle", 32'(ch_active), 32'h0);
        rd(A_CNT_L, 8'h00, "t5_cnt_zero");

        // EN=0 freezes; then W1C drops a granted irq
        wr(A_CTRL, 8'h00);
        rd(A_CTRL, 8'h00, "en_off");
        wr(A_CNT_L, 8'h01);
        wr(A_CNT_H, 8'h00);
        check("en_armed", 32'(ch_active), 32'h4);
        pulse(1, 0, 0, 0, 3'd0);
        rd(A_CNT_L, 8'h01, "en_frozen");
        rd(A_FLAGS, 8'h00, "en_no_flag");
        wr(A_CTRL, 8'h01);
        pulse(1, 0, 0, 1, 3'd2); step();
        wr(A_FLAGS, 8'h04); step();
        rd(A_VEC, 8'h02, "w1c_irq_drop");
        rd(A_FLAGS, 8'h00, "w1c_flags");

        // Expiry coinciding with ack of the same channel
        program_ch(3'd1, 8'h07, 16'd1);
        pulse(0, 1, 0, 1, 3'd1); step();
        pulse(0, 1, 1, 1, 3'd1);
        rd(A_FLAGS, 8'h02, "t6_flag_kept");
        rd(A_MODE, MODE_AFTER_OVERRUN, "t6_mode_ovr");
        pulse(0, 0, 1, 0, 3'd0);
        rd(A_FLAGS, 8'h00, "t6_flags_acked");
        wr(A_FLAGS, 8'h02);
        rd(A_MODE, 8'h07, "t6_ovr_cleared");
        wr(A_CNT_L, 8'h00);
        wr(A_CNT_H, 8'h00);

        // Ack while irq=0 is ignored (IE off, so no irq)
        wr(A_MODE, 8'h04);
        wr(A_CNT_L, 8'h01);
        wr(A_CNT_H, 8'h00);
        pulse(0, 1, 0, 0, 3'd0);
        pulse(0, 0, 1, 0, 3'd0);
        rd(A_FLAGS, 8'h02, "ack_ignored");

        // Enabling IE raises irq; reset mid-grant clears everything at once
        irq_q.push_back('{vec: 3'd1, at: cyc + 2});
        wr(A_MODE, 8'h06);
        step(); step();
        reset_n = 1'b0;
        #1;
        check("async_rst_irq", 32'(bus.irq), 32'd0);
        check("async_rst_vector", 32'(bus.irq_vector), 32'd0);
        check("async_rst_active", 32'(ch_active), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        rd(A_CTRL, 8'h01, "post_rst_ctrl");
        rd(A_FLAGS, 8'h00, "post_rst_flags");
        rd(A_VEC, 8'h00, "post_rst_vec");
        rd(A_MODE, 8'h00, "post_rst_mode");
        step(); step();

        check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        check("irq_queue_empty", 32'(irq_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
